// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states,
// instruction fields, datapath mux select codes and ALU operations.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_INIT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // One class per distinct control sequence; the five R-type ALU ops share one.
  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_JR      = 4'd1,
    C_LW      = 4'd2,
    C_SW      = 4'd3,
    C_ADDI    = 4'd4,
    C_ORI     = 4'd5,
    C_LUI     = 4'd6,
    C_BEQ     = 4'd7,
    C_BNE     = 4'd8,
    C_J       = 4'd9,
    C_JAL     = 4'd10,
    C_ILLEGAL = 4'd15
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] PC_SEL_ALU    = 3'd0;
  localparam logic [2:0] PC_SEL_ALUOUT = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
  localparam logic [2:0] PC_SEL_REG_A  = 3'd3;

  localparam logic [2:0] ALUA_PC    = 3'd0;
  localparam logic [2:0] ALUA_REG_A = 3'd1;

  localparam logic [2:0] ALUB_REG_B    = 3'd0;
  localparam logic [2:0] ALUB_FOUR     = 3'd1;
  localparam logic [2:0] ALUB_SEXT_IMM = 3'd2;
  localparam logic [2:0] ALUB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] ALUB_ZEXT_IMM = 3'd4;

  localparam logic [2:0] WB_ALUOUT = 3'd0;
  localparam logic [2:0] WB_MDR    = 3'd1;
  localparam logic [2:0] WB_PC     = 3'd2;
  localparam logic [2:0] WB_LUI    = 3'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath that consumes the selects.
interface mc_ctrl_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_re;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic [2:0] pc_sel;
  logic [2:0] alua_sel;
  logic [2:0] alub_sel;
  logic [2:0] wb_sel;
  logic [1:0] rf_dst_sel;
  logic [2:0] alu_op;
  logic       retire;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_re, mem_we, mem_addr_sel, ir_we, pc_we, rf_we,
           pc_sel, alua_sel, alub_sel, wb_sel, rf_dst_sel, alu_op,
           retire, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_re, mem_we, mem_addr_sel, ir_we, pc_we, rf_we,
           pc_sel, alua_sel, alub_sel, wb_sel, rf_dst_sel, alu_op,
           retire, illegal, state
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps opcode/funct to a control class,
// the ALU operation used in EXEC, and an illegal-instruction flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output alu_op_e      alu_op,
  output logic         illegal
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    cls    = C_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        cls = C_RTYPE;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_JR:   cls    = C_JR;
          default: cls    = C_ILLEGAL;
        endcase
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_ADDI: cls = C_ADDI;
      OP_ORI: begin
        cls    = C_ORI;
        alu_op = ALU_OR;
      end
      OP_LUI: cls = C_LUI;
      OP_BEQ: begin
        cls    = C_BEQ;
        alu_op = ALU_SUB;
      end
      OP_BNE: begin
        cls    = C_BNE;
        alu_op = ALU_SUB;
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

  assign illegal = (cls == C_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: a Moore state register with combinational outputs
// decoded from state, instruction class and zero; memory states wait on ready.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  mc_ctrl_if.master bus
);

  state_e       state_q, state_d;
  instr_class_e dec_cls;
  alu_op_e      dec_alu_op;
  logic         dec_illegal;

  mc_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  // NOTE: state is a flop, so it is assigned with <= only; the async reset
  // lands it in INIT, whose outputs are all zero, so outputs drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.mem_re       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.rf_we        = 1'b0;
    bus.pc_sel       = PC_SEL_ALU;
    bus.alua_sel     = ALUA_PC;
    bus.alub_sel     = ALUB_REG_B;
    bus.wb_sel       = WB_ALUOUT;
    bus.rf_dst_sel   = DST_RT;
    bus.alu_op       = ALU_ADD;
    bus.retire       = 1'b0;
    bus.illegal      = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        bus.mem_re   = 1'b1;
        bus.alub_sel = ALUB_FOUR;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = S_DECODE;
        end
      end

      // Branch target is computed speculatively into ALUOut for every opcode.
      S_DECODE: begin
        bus.alub_sel = ALUB_SEXT_SH2;
        if (dec_illegal) begin
          bus.illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (dec_cls)
          C_RTYPE: begin
            bus.alua_sel = ALUA_REG_A;
            bus.alub_sel = ALUB_REG_B;
            bus.alu_op   = dec_alu_op;
            state_d      = S_WB;
          end
          C_JR: begin
            bus.pc_sel = PC_SEL_REG_A;
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
          end
          C_LW, C_SW: begin
            bus.alua_sel = ALUA_REG_A;
            bus.alub_sel = ALUB_SEXT_IMM;
            bus.alu_op   = dec_alu_op;
            state_d      = S_MEM;
          end
          C_ADDI: begin
            bus.alua_sel = ALUA_REG_A;
            bus.alub_sel = ALUB_SEXT_IMM;
            bus.alu_op   = dec_alu_op;
            state_d      = S_WB;
          end
          C_ORI: begin
            bus.alua_sel = ALUA_REG_A;
            bus.alub_sel = ALUB_ZEXT_IMM;
            bus.alu_op   = dec_alu_op;
            state_d      = S_WB;
          end
          C_LUI: state_d = S_WB;
          C_BEQ, C_BNE: begin
            bus.alua_sel = ALUA_REG_A;
            bus.alub_sel = ALUB_REG_B;
            bus.alu_op   = dec_alu_op;
            bus.pc_sel   = PC_SEL_ALUOUT;
            bus.pc_we    = (dec_cls == C_BEQ) ? bus.zero : !bus.zero;
            bus.retire   = 1'b1;
          end
          C_J: begin
            bus.pc_sel = PC_SEL_JUMP;
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
          end
          // The PC already holds PC+4 here, which is exactly the link value.
          C_JAL: begin
            bus.pc_sel     = PC_SEL_JUMP;
            bus.pc_we      = 1'b1;
            bus.rf_we      = 1'b1;
            bus.wb_sel     = WB_PC;
            bus.rf_dst_sel = DST_RA;
            bus.retire     = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        bus.mem_addr_sel = 1'b1;
        if (dec_cls == C_LW) bus.mem_re = 1'b1;
        else                 bus.mem_we = 1'b1;
        if (bus.mem_ready) begin
          if (dec_cls == C_LW) begin
            state_d = S_WB;
          end else begin
            bus.retire = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end

      S_WB: begin
        bus.rf_we  = 1'b1;
        bus.retire = 1'b1;
        state_d    = S_FETCH;
        case (dec_cls)
          C_RTYPE: bus.rf_dst_sel = DST_RD;
          C_LW:    bus.wb_sel     = WB_MDR;
          C_LUI:   bus.wb_sel     = WB_LUI;
          default: bus.wb_sel     = WB_ALUOUT;
        endcase
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction cycle-trace model built
// from the instruction's control recipe, compared against the DUT every cycle.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       re, we, mas, ir, pcw, rf;
    logic [2:0] pcs, aa, ab, wb;
    logic [1:0] dst;
    logic [2:0] op;
    logic       ret, ill;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  out_t exp_q[$];
  bit   rdy_q[$];

  mc_ctrl_if bus();

  mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t r;
    r.st  = bus.state;
    r.re  = bus.mem_re;
    r.we  = bus.mem_we;
    r.mas = bus.mem_addr_sel;
    r.ir  = bus.ir_we;
    r.pcw = bus.pc_we;
    r.rf  = bus.rf_we;
    r.pcs = bus.pc_sel;
    r.aa  = bus.alua_sel;
    r.ab  = bus.alub_sel;
    r.wb  = bus.wb_sel;
    r.dst = bus.rf_dst_sel;
    r.op  = bus.alu_op;
    r.ret = bus.retire;
    r.ill = bus.illegal;
    return r;
  endfunction

  function automatic out_t blank(input logic [2:0] st);
    out_t r = '0;
    r.st = st;
    return r;
  endfunction

  task automatic check_vec(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%h exp=%h (st/re/we/mas/ir/pcw/rf/pcs/aa/ab/wb/dst/op/ret/ill)",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic bit is_rtype(input string m);
    return m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt";
  endfunction

  function automatic bit is_bad(input string m);
    return m == "bad_op" || m == "bad_fn";
  endfunction

  task automatic encode(input string m, output logic [5:0] op, output logic [5:0] fn);
    op = 6'h00; fn = 6'h00;
    if      (m == "add")    fn = 6'h20;
    else if (m == "sub")    fn = 6'h22;
    else if (m == "and")    fn = 6'h24;
    else if (m == "or")     fn = 6'h25;
    else if (m == "slt")    fn = 6'h2A;
    else if (m == "jr")     fn = 6'h08;
    else if (m == "bad_fn") fn = 6'h21;
    else if (m == "lw")     op = 6'h23;
    else if (m == "sw")     op = 6'h2B;
    else if (m == "addi")   op = 6'h08;
    else if (m == "ori")    op = 6'h0D;
    else if (m == "lui")    op = 6'h0F;
    else if (m == "beq")    op = 6'h04;
    else if (m == "bne")    op = 6'h05;
    else if (m == "j")      op = 6'h02;
    else if (m == "jal")    op = 6'h03;
    else                    op = 6'h3F;
  endtask

  function automatic logic [2:0] alu_of(input string m);
    if (m == "sub" || m == "beq" || m == "bne") return 3'd1;
    if (m == "and") return 3'd2;
    if (m == "or" || m == "ori") return 3'd3;
    if (m == "slt") return 3'd4;
    return 3'd0;
  endfunction

  task automatic push(input out_t r, input bit rdy);
    exp_q.push_back(r);
    rdy_q.push_back(rdy);
  endtask

  // Expected cycle trace of one instruction: fetch (with waits), decode,
  // the instruction's execute recipe, then memory and/or writeback phases.
  task automatic build(input string m, input bit z, input int fw, input int mw);
    out_t r;
    for (int i = 0; i <= fw; i++) begin
      r = blank(3'd0); r.re = 1; r.ab = 3'd1;
      if (i == fw) begin r.ir = 1; r.pcw = 1; end
      push(r, i == fw);
    end
    r = blank(3'd1); r.ab = 3'd3;
    if (is_bad(m)) begin r.ill = 1; push(r, 1); return; end
    push(r, 1);

    r = blank(3'd2);
    if (is_rtype(m) || m == "lw" || m == "sw" || m == "addi" || m == "ori" ||
        m == "beq" || m == "bne") begin
      r.aa = 3'd1;
      r.op = alu_of(m);
    end
    if (m == "lw" || m == "sw" || m == "addi") r.ab = 3'd2;
    if (m == "ori") r.ab = 3'd4;
    if (m == "jr") begin r.pcs = 3'd3; r.pcw = 1; r.ret = 1; end
    if (m == "beq" || m == "bne") begin
      r.pcs = 3'd1; r.ret = 1;
      r.pcw = (m == "beq") ? z : !z;
    end
    if (m == "j")   begin r.pcs = 3'd2; r.pcw = 1; r.ret = 1; end
    if (m == "jal") begin
      r.pcs = 3'd2; r.pcw = 1; r.rf = 1; r.wb = 3'd2; r.dst = 2'd2; r.ret = 1;
    end
    push(r, 1);
    if (r.ret) return;

    if (m == "lw" || m == "sw") begin
      for (int i = 0; i <= mw; i++) begin
        r = blank(3'd3); r.mas = 1;
        if (m == "lw") r.re = 1; else r.we = 1;
        if (m == "sw" && i == mw) r.ret = 1;
        push(r, i == mw);
      end
      if (m == "sw") return;
    end

    r = blank(3'd4); r.rf = 1; r.ret = 1;
    if (is_rtype(m)) r.dst = 2'd1;
    if (m == "lw")  r.wb = 3'd1;
    if (m == "lui") r.wb = 3'd3;
    push(r, 1);
  endtask

  // Drives one instruction cycle by cycle and compares every output each cycle.
  task automatic run(input string m, input bit z, input int fw, input int mw,
                     input int exp_len, input bit abort_in_mem);
    logic [5:0] op, fn;
    out_t e;
    int   rets = 0;
    exp_q.delete();
    rdy_q.delete();
    build(m, z, fw, mw);
    check_int({"len_", m}, exp_q.size(), exp_len);
    encode(m, op, fn);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.zero      = z;
      bus.mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      #1;
      check_vec({"cyc_", m}, sample(), e);
      rets += int'(bus.retire);
      if (abort_in_mem && e.st == 3'd3) begin
        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_mid_mem", sample(), blank(3'd7));
        check_int("rst_mem_we", int'(bus.mem_we), 0);
        exp_q.delete();
        rdy_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_vec("rst_release_init", sample(), blank(3'd7));
        return;
      end
    end
    check_int({"retire_", m}, rets, is_bad(m) ? 0 : 1);
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check_vec("reset_hold", sample(), blank(3'd7));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_vec("init_after_release", sample(), blank(3'd7));

    run("add",    1'b0, 0, 0, 4, 1'b0);
    run("sub",    1'b0, 1, 0, 5, 1'b0);
    run("and",    1'b0, 0, 0, 4, 1'b0);
    run("or",     1'b0, 0, 0, 4, 1'b0);
    run("slt",    1'b0, 0, 0, 4, 1'b0);
    run("jr",     1'b0, 0, 0, 3, 1'b0);
    run("lw",     1'b0, 0, 3, 8, 1'b0);
    run("lw",     1'b0, 2, 0, 7, 1'b0);
    run("sw",     1'b0, 0, 0, 4, 1'b0);
    run("sw",     1'b0, 0, 1, 5, 1'b0);
    run("addi",   1'b0, 0, 0, 4, 1'b0);
    run("ori",    1'b0, 0, 0, 4, 1'b0);
    run("lui",    1'b0, 0, 0, 4, 1'b0);
    run("beq",    1'b1, 0, 0, 3, 1'b0);
    run("beq",    1'b0, 0, 0, 3, 1'b0);
    run("bne",    1'b1, 0, 0, 3, 1'b0);
    run("bne",    1'b0, 0, 0, 3, 1'b0);
    run("j",      1'b0, 0, 0, 3, 1'b0);
    run("jal",    1'b0, 0, 0, 3, 1'b0);
    run("bad_op", 1'b0, 0, 0, 2, 1'b0);
    run("bad_fn", 1'b0, 0, 0, 2, 1'b0);
    run("sw",     1'b0, 0, 5, 9, 1'b1);
    run("add",    1'b0, 0, 0, 4, 1'b0);

    @(negedge clk);
    #1 check_int("final_state_fetch", int'(bus.state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control state machine for the 32-bit MIPS-subset CPU. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the select lines of the datapath's 8-input operand and writeback multiplexers, the register/PC/IR write enables and the ALU operation. Memory accesses stall on a ready handshake.

## Interface
- No parameters; all encodings are fixed in `mc_pkg`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from the DECODE state onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_re`, `mem_we` out 1: memory read / write request.
- `mem_addr_sel` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `ir_we`, `pc_we`, `rf_we` out 1: instruction register, PC and register-file write enables.
- `pc_sel` out 3: PC source. 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target, 3 = reg A (jr).
- `alua_sel` out 3: ALU A source. 0 = PC, 1 = reg A.
- `alub_sel` out 3: ALU B source. 0 = reg B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2, 4 = zero-extended imm.
- `wb_sel` out 3: writeback source. 0 = ALUOut, 1 = MDR, 2 = PC (link), 3 = imm<<16.
- `rf_dst_sel` out 2: destination register. 0 = rt, 1 = rd, 2 = $31.
- `alu_op` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse when an unsupported opcode or funct is decoded.
- `state` out 3: current state, for debug.

## Operation
- States: INIT=7, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5 and 6 are unreachable and recover to FETCH.
- Select codes 5–7 are never driven (the muxes output 0 for those codes).
- **INIT**: all outputs 0. Next state is FETCH.
- **FETCH**:
  - Drives mem_re=1, mem_addr_sel=0, alua_sel=0, alub_sel=1, alu_op=ADD, pc_sel=0.
  - While mem_ready=0, holds in FETCH with ir_we=pc_we=0.
  - When mem_ready=1, asserts ir_we=pc_we=1 and moves to DECODE.
- **DECODE**: alua_sel=0, alub_sel=3, alu_op=ADD (branch target into ALUOut). Next state is EXEC; for an illegal instruction, illegal=1 and next state is FETCH.
- **EXEC**, by instruction:
  - R-type (add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A): alua=1, alub=0, alu_op from funct. Next: WB.
  - jr (0x08): pc_sel=3, pc_we=1, retire. Next: FETCH.
  - lw (0x23) / sw (0x2B): alua=1, alub=2, ADD. Next: MEM.
  - addi (0x08): alua=1, alub=2, ADD. Next: WB.
  - ori (0x0D): alua=1, alub=4, OR. Next: WB.
  - lui (0x0F): no ALU use. Next: WB.
  - beq (0x04) / bne (0x05): alua=1, alub=0, SUB. pc_sel=1 and pc_we = zero (beq) or !zero (bne). retire. Next: FETCH.
  - j (0x02): pc_sel=2, pc_we=1, retire. Next: FETCH.
  - jal (0x03): pc_sel=2, pc_we=1, rf_we=1, wb_sel=2, rf_dst_sel=2, retire. The link value is the pre-edge PC (already PC+4). Next: FETCH.
- **MEM**: mem_addr_sel=1.
  - lw: mem_re=1; holds until mem_ready=1, then next state is WB.
  - sw: mem_we=1; holds until mem_ready=1, then retire and next state is FETCH.
- **WB**: rf_we=1, retire. Next: FETCH.
  - R-type: wb_sel=0, rf_dst_sel=1.
  - addi / ori: wb_sel=0, rf_dst_sel=0.
  - lw: wb_sel=1, rf_dst_sel=0.
  - lui: wb_sel=3, rf_dst_sel=0.
- Every output not listed for a state is 0.

## Timing
- Moore state register. Outputs are combinational from state, opcode, funct and zero. pc_we/ir_we in FETCH and the MEM exit depend on mem_ready (Mealy on ready).
- Zero-wait-state cycle counts: R-type/addi/ori/lui 4, lw 5, sw 4, beq/bne/j/jal/jr 3. Each memory wait cycle adds 1.
- Asserting rst_n low at any time forces state to INIT immediately; all outputs go to 0 asynchronously. An in-flight access is abandoned with no write enable.
- The first FETCH occurs in the second cycle after rst_n deasserts.
- mem_re/mem_we stay constant for the whole wait.

## Structure
- `mc_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - pc/alua/alub/wb/dst select codes;
  - alu_op codes.
- Sub-module `mc_decode` (combinational): opcode/funct → instruction class, alu_op, illegal flag. `mc_ctrl` holds the FSM and the output logic.

## Test plan
- Reset release, mem_ready=1: all outputs 0 in INIT; next cycle FETCH with mem_re=1, ir_we=1, pc_we=1, alub_sel=1.
- add (opcode 0, funct 0x20): state sequence 0,1,2,4,0; in WB rf_we=1, wb_sel=0, rf_dst_sel=1; retire pulses once.
- lw with mem_ready low for 3 cycles in MEM: MEM lasts 4 cycles with mem_re=1 throughout; WB has wb_sel=1; total 8 cycles.
- beq with zero=1 → pc_we=1, pc_sel=1; repeat with zero=0 → pc_we=0; bne gives the inverse.
- jal: a single EXEC cycle with pc_sel=2, rf_we=1, wb_sel=2, rf_dst_sel=2.
- opcode 0x3F: illegal pulses in DECODE, then FETCH, and rf_we/mem_we never assert. Separately, rst_n low mid-MEM of sw: mem_we drops the same cycle and state=7.
